imem_stream_loader: RTL and testbench
=====================================

# imem_stream_loader

Parametrised instruction-memory loader; successor to the fixed 3-bit-address, 32-bit-word loader. Assembles a stream of UART receive bytes into DATA_W-bit words (little-endian), writes each completed word to instruction memory at an auto-incrementing address, and reports fill status, overrun and an optional checksum. Sits between the UART receiver and the instruction RAM write port.

## Interface
- DATA_W, 32, word width in bits; a multiple of 8, at least 8.
- ADDR_W, 3, memory address width; DEPTH = 2**ADDR_W words.
- WRAP, 0, 0 = stop loading when memory is full; 1 = wrap the address to 0 and keep loading.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_byte_valid  in  1  UART byte-ready level or pulse from the receiver; rising-edge detected internally.
- i_byte  in  8  received byte; stable from the i_byte_valid rise through the following 2 clk edges.
- i_clear  in  1  synchronous restart of the load session; highest priority after reset.
- o_we  out  1  memory write strobe; one cycle per word.
- o_addr  out  ADDR_W  write address.
- o_data  out  DATA_W  write data.
- o_word_count  out  ADDR_W+1  number of words written, saturating at DEPTH.
- o_busy  out  1  partial word in progress, or a write/advance is pending.
- o_full  out  1  sticky; set when o_word_count reaches DEPTH.
- o_overrun  out  1  sticky; a byte edge was dropped.
- o_checksum  out  DATA_W  running XOR of written words (see Configuration).
- o_debug_flag  out  1  toggles once per word written.

## Operation
- Byte edge detection:
  - r_sync <= {r_sync[0], i_byte_valid}.
  - A byte event occurs when r_sync == 2'b01.
- States: COLLECT, WRITE, ADVANCE, FULL.
- COLLECT:
  - On a byte event, i_byte is placed into lane r_idx: bits [8*r_idx+7 : 8*r_idx] of the assembly register, and r_idx increments.
  - When r_idx == NBYTES-1 (NBYTES = DATA_W/8) on an event, the full word is copied to o_data, r_idx goes to 0, and the state moves to WRITE.
- WRITE: o_we <= 1; o_debug_flag toggles; checksum updates; state moves to ADVANCE.
- ADVANCE:
  - o_we <= 0; o_word_count increments, saturating at DEPTH.
  - If o_addr == DEPTH-1 and WRAP = 0: o_full <= 1 and state moves to FULL; o_addr holds.
  - Otherwise: o_addr <= o_addr + 1 (mod DEPTH); the state returns to COLLECT; if this was the DEPTH-th word, o_full <= 1.
- FULL: byte events are ignored; o_overrun is not set; the state is left only by i_clear or rst.
- A byte event in WRITE or ADVANCE is dropped and sets o_overrun. Assembly continues with the next event.
- i_clear in any state, at the next edge:
  - State returns to COLLECT.
  - r_idx, o_addr, o_word_count, o_full, o_overrun and o_checksum are zeroed; o_we is 0.
  - o_data and o_debug_flag hold.
  - Any byte event on the same edge is discarded.
- o_data holds the last written word between writes; it is not cleared after the write.
- o_busy = (r_idx != 0) or state in {WRITE, ADVANCE}.

## Timing
- Reset values: all outputs 0; state COLLECT; r_sync 2'b00; r_idx 0.
- Reset asserted mid-word or mid-write:
  - o_we drops immediately (asynchronously).
  - The partial word is lost.
- i_byte_valid rising before edge E0 gives a byte event in the cycle after E0; the byte is captured at edge E0+1.
- Final byte captured at edge E:
  - o_data is valid after E.
  - o_we is high from E+1 to E+2.
  - o_addr increments at E+2.
  - The earliest next capture is at E+3.
- o_addr and o_data are stable throughout the o_we cycle.
- Minimum byte spacing without overrun: 3 clk cycles between byte events.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - o_checksum <= o_checksum ^ word in WRITE.
  - Zeroed by rst or i_clear.
- Not defined: o_checksum is tied to 0 and no checksum register is built.

## Test plan
- Default params, bytes 0x13,0x00,0x50,0x00 at 16-cycle spacing -> one o_we pulse, o_addr=0, o_data=0x00500013, o_word_count=1, o_debug_flag=1.
- Load 8 words, WRAP=0 -> o_addr 0..7, o_full=1 after the 8th write; a 9th word's bytes produce no o_we and o_overrun stays 0.
- WRAP=1, 9 words -> the 9th write goes to o_addr=0; o_word_count=8; o_full=1.
- Second byte event exactly 1 cycle after a word-completing byte -> o_overrun=1; the following 4 bytes still assemble into one word.
- 2 bytes sent, then i_clear pulsed -> o_busy=0, o_addr=0; the next 4 bytes form a complete word at address 0. Separately, rst asserted during the o_we cycle -> o_we=0 immediately and all outputs 0.
- IMEM_LOADER_CHECKSUM_EN, words 0xFFFF0000 then 0x0F0F0F0F -> o_checksum=0xF0F00F0F; without the macro -> o_checksum=0.

Source files
------------

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: packs UART receive bytes little-endian into DATA_W-bit
// words and writes each completed word to instruction memory at an
// auto-incrementing address, with fill, overrun and debug status.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to build a running XOR
// checksum of all written words; otherwise o_checksum is tied to zero.
module imem_stream_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3,
    parameter bit          WRAP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    input  logic              i_clear,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_overrun,
    output logic [DATA_W-1:0] o_checksum,
    output logic              o_debug_flag
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WRITE   = 2'd1,
        S_ADVANCE = 2'd2,
        S_FULL    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [DATA_W-1:0]   asm_next;
    logic [IDX_W+2:0]    lane_lo;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                full_q, full_d;
    logic                ovr_q, ovr_d;
    logic                dbg_q, dbg_d;
    logic [DATA_W-1:0]   cks_q, cks_d;
    logic                byte_evt;

    // Rising edge of the receiver's byte-ready, seen one cycle after sampling
    assign byte_evt = (sync_q == 2'b01);

    // Next-state and output-register logic; i_clear overrides everything
    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[0], i_byte_valid};
        idx_d    = idx_q;
        asm_d    = asm_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        ovr_d    = ovr_q;
        dbg_d    = dbg_q;
        cks_d    = cks_q;
        lane_lo  = {idx_q, 3'b000};
        asm_next = asm_q;
        asm_next[lane_lo +: 8] = i_byte;

        case (state_q)
            S_COLLECT: begin
                if (byte_evt) begin
                    asm_d = asm_next;
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        data_d  = asm_next;
                        idx_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                we_d    = 1'b1;
                dbg_d   = ~dbg_q;
                cks_d   = cks_q ^ data_q;
                state_d = S_ADVANCE;
                if (byte_evt) ovr_d = 1'b1;
            end
            S_ADVANCE: begin
                we_d = 1'b0;
                if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + 1'b1;
                if (!WRAP && (addr_q == ADDR_W'(DEPTH - 1))) begin
                    full_d  = 1'b1;
                    state_d = S_FULL;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_COLLECT;
                    if (cnt_q == CNT_W'(DEPTH - 1)) full_d = 1'b1;
                end
                if (byte_evt) ovr_d = 1'b1;
            end
            default: begin
                // S_FULL: byte events are silently ignored
            end
        endcase

        if (i_clear) begin
            state_d = S_COLLECT;
            idx_d   = '0;
            asm_d   = asm_q;
            we_d    = 1'b0;
            addr_d  = '0;
            data_d  = data_q;
            cnt_d   = '0;
            full_d  = 1'b0;
            ovr_d   = 1'b0;
            dbg_d   = dbg_q;
            cks_d   = '0;
        end

        busy_d = (idx_d != '0) || (state_d == S_WRITE) || (state_d == S_ADVANCE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_COLLECT;
            sync_q  <= 2'b00;
            idx_q   <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            dbg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            dbg_q   <= dbg_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of every word written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cks_q <= '0;
        else      cks_q <= cks_d;
    end
`else
    assign cks_q = '0;
`endif

    assign o_we         = we_q;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_word_count = cnt_q;
    assign o_busy       = busy_q;
    assign o_full       = full_q;
    assign o_overrun    = ovr_q;
    assign o_checksum   = cks_q;
    assign o_debug_flag = dbg_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: a no-wrap and a wrap instance share
// the same byte stream; expected values are hand-computed constants.
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        i_clear;

    logic        we0, busy0, full0, ovr0, dbg0;
    logic [2:0]  addr0;
    logic [31:0] data0, cks0;
    logic [3:0]  cnt0;
    logic        we1, busy1, full1, ovr1, dbg1;
    logic [2:0]  addr1;
    logic [31:0] data1, cks1;
    logic [3:0]  cnt1;

    int n_vec = 0;
    int n_err = 0;
    int n_we0 = 0, n_we1 = 0;
    logic [31:0] lw_addr0, lw_data0, lw_addr1, lw_data1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [31:0] CKS_A = 32'hFFFF0000;
    localparam logic [31:0] CKS_B = 32'hF0F00F0F;
`else
    localparam logic [31:0] CKS_A = 32'h0;
    localparam logic [31:0] CKS_B = 32'h0;
`endif

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic [31:0] cnt;
        logic [31:0] full;
        logic [31:0] dbg;
    } vec_t;

    vec_t vecs[8];

    imem_stream_loader #(.DATA_W(32), .ADDR_W(3), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
        .i_clear(i_clear), .o_we(we0), .o_addr(addr0), .o_data(data0),
        .o_word_count(cnt0), .o_busy(busy0), .o_full(full0),
        .o_overrun(ovr0), .o_checksum(cks0), .o_debug_flag(dbg0)
    );

    imem_stream_loader #(.DATA_W(32), .ADDR_W(3), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
        .i_clear(i_clear), .o_we(we1), .o_addr(addr1), .o_data(data1),
        .o_word_count(cnt1), .o_busy(busy1), .o_full(full1),
        .o_overrun(ovr1), .o_checksum(cks1), .o_debug_flag(dbg1)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen on each instance
    always @(negedge clk) begin
        if (we0) begin n_we0++; lw_addr0 = 32'(addr0); lw_data0 = data0; end
        if (we1) begin n_we1++; lw_addr1 = 32'(addr1); lw_data1 = data1; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        repeat (8) @(negedge clk);
        i_byte_valid = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base0, base1;
        logic seen;
        vecs[0] = '{32'h00500013, 32'd0, 32'd1, 32'd0, 32'd1};
        vecs[1] = '{32'h11223344, 32'd1, 32'd2, 32'd0, 32'd0};
        vecs[2] = '{32'hDEADBEEF, 32'd2, 32'd3, 32'd0, 32'd1};
        vecs[3] = '{32'h00000000, 32'd3, 32'd4, 32'd0, 32'd0};
        vecs[4] = '{32'hFFFFFFFF, 32'd4, 32'd5, 32'd0, 32'd1};
        vecs[5] = '{32'h80000001, 32'd5, 32'd6, 32'd0, 32'd0};
        vecs[6] = '{32'h0A0B0C0D, 32'd6, 32'd7, 32'd0, 32'd1};
        vecs[7] = '{32'h12345678, 32'd7, 32'd8, 32'd1, 32'd0};

        rst = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00; i_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_we",   32'(we0),   32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_data", data0,      32'd0);
        chk("rst_cnt",  32'(cnt0),  32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_ovr",  32'(ovr0),  32'd0);
        chk("rst_cks",  cks0,       32'd0);
        chk("rst_dbg",  32'(dbg0),  32'd0);

        // Fill memory with eight words
        base0 = n_we0; base1 = n_we1;
        for (int k = 0; k < 8; k++) begin
            send_word(vecs[k].word);
            chk("fill_nwe0",  32'(n_we0 - base0), 32'(k + 1));
            chk("fill_waddr", lw_addr0,           vecs[k].addr);
            chk("fill_wdata", lw_data0,           vecs[k].word);
            chk("fill_data",  data0,              vecs[k].word);
            chk("fill_cnt",   32'(cnt0),          vecs[k].cnt);
            chk("fill_full",  32'(full0),         vecs[k].full);
            chk("fill_dbg",   32'(dbg0),          vecs[k].dbg);
            chk("fill_ovr",   32'(ovr0),          32'd0);
            chk("fill_busy",  32'(busy0),         32'd0);
            chk("fill_cnt1",  32'(cnt1),          vecs[k].cnt);
            chk("fill_nwe1",  32'(n_we1 - base1), 32'(k + 1));
        end
        chk("full_addr0", 32'(addr0), 32'd7);
        chk("wrap_addr1", 32'(addr1), 32'd0);

        // Ninth word: ignored when full without wrap, lands at 0 with wrap
        send_word(32'hCAFEF00D);
        chk("ninth_nwe0",  32'(n_we0 - base0), 32'd8);
        chk("ninth_ovr0",  32'(ovr0),          32'd0);
        chk("ninth_busy0", 32'(busy0),         32'd0);
        chk("ninth_cnt0",  32'(cnt0),          32'd8);
        chk("ninth_addr0", 32'(addr0),         32'd7);
        chk("ninth_data0", data0,              32'h12345678);
        chk("ninth_nwe1",  32'(n_we1 - base1), 32'd9);
        chk("ninth_wadr1", lw_addr1,           32'd0);
        chk("ninth_wdat1", lw_data1,           32'hCAFEF00D);
        chk("ninth_cnt1",  32'(cnt1),          32'd8);
        chk("ninth_full1", 32'(full1),         32'd1);
        chk("ninth_addr1", 32'(addr1),         32'd1);

        // Clear: counters and flags zeroed, data and debug flag hold
        pulse_clear();
        chk("clr_addr0", 32'(addr0), 32'd0);
        chk("clr_cnt0",  32'(cnt0),  32'd0);
        chk("clr_full0", 32'(full0), 32'd0);
        chk("clr_busy0", 32'(busy0), 32'd0);
        chk("clr_data0", data0,      32'h12345678);
        chk("clr_dbg0",  32'(dbg0),  32'd0);
        chk("clr_data1", data1,      32'hCAFEF00D);
        chk("clr_dbg1",  32'(dbg1),  32'd1);
        chk("clr_addr1", 32'(addr1), 32'd0);
        chk("clr_full1", 32'(full1), 32'd0);

        // Overrun: extra byte edge lands in the ADVANCE cycle
        base0 = n_we0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        @(negedge clk);
        i_byte = 8'h04; i_byte_valid = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
        @(negedge clk);
        i_byte = 8'hEE; i_byte_valid = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovr_flag",  32'(ovr0),          32'd1);
        chk("ovr_nwe",   32'(n_we0 - base0), 32'd1);
        chk("ovr_wdata", lw_data0,           32'h04030201);
        chk("ovr_busy",  32'(busy0),         32'd0);
        send_word(32'h55AA6699);
        chk("ovr_nwe2",  32'(n_we0 - base0), 32'd2);
        chk("ovr_wadr2", lw_addr0,           32'd1);
        chk("ovr_wdat2", lw_data0,           32'h55AA6699);
        chk("ovr_cnt",   32'(cnt0),          32'd2);
        chk("ovr_stick", 32'(ovr0),          32'd1);

        // Partial word discarded by clear, then write latency of a fresh word
        send_byte(8'hA1); send_byte(8'hA2);
        chk("part_busy", 32'(busy0), 32'd1);
        pulse_clear();
        chk("pclr_busy", 32'(busy0), 32'd0);
        chk("pclr_addr", 32'(addr0), 32'd0);
        chk("pclr_ovr",  32'(ovr0),  32'd0);
        chk("pclr_cnt",  32'(cnt0),  32'd0);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        @(negedge clk);
        i_byte = 8'h40; i_byte_valid = 1'b1;
        @(negedge clk);
        chk("lat_e0_we",   32'(we0),   32'd0);
        @(negedge clk);
        chk("lat_e1_we",   32'(we0),   32'd0);
        chk("lat_e1_data", data0,      32'h40302010);
        chk("lat_e1_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        chk("lat_e2_we",   32'(we0),   32'd1);
        chk("lat_e2_addr", 32'(addr0), 32'd0);
        @(negedge clk);
        chk("lat_e3_we",   32'(we0),   32'd0);
        chk("lat_e3_addr", 32'(addr0), 32'd1);
        chk("lat_e3_cnt",  32'(cnt0),  32'd1);
        i_byte_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Checksum over two words
        pulse_clear();
        chk("cks_clr", cks0, 32'd0);
        send_word(32'hFFFF0000);
        chk("cks_a", cks0, CKS_A);
        send_word(32'h0F0F0F0F);
        chk("cks_b", cks0, CKS_B);

        // Reset asserted during the write strobe
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(negedge clk);
        i_byte = 8'h44; i_byte_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (we0) seen = 1'b1;
        end
        chk("rw_we_seen", 32'(seen), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rw_we",   32'(we0),   32'd0);
        chk("rw_addr", 32'(addr0), 32'd0);
        chk("rw_data", data0,      32'd0);
        chk("rw_cnt",  32'(cnt0),  32'd0);
        chk("rw_busy", 32'(busy0), 32'd0);
        chk("rw_full", 32'(full0), 32'd0);
        chk("rw_ovr",  32'(ovr0),  32'd0);
        chk("rw_cks",  cks0,       32'd0);
        chk("rw_dbg",  32'(dbg0),  32'd0);
        i_byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rw_post_busy", 32'(busy0), 32'd0);
        chk("rw_post_we",   32'(we0),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
